fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Read-side consumer for the asynchronous FIFO. It runs in the FIFO read clock domain, pops one word whenever the FIFO is non-empty and output is enabled, and serialises the word onto a single UART-style line. The frame is a start bit, WIDTH data bits sent LSB first, and a stop bit. The line drives an output pin directly.

Parameters:
WIDTH, 3, data word width; must match the FIFO data width.
CLKS_PER_BIT, 4, clk cycles per serial bit, >=1; bit counter width is $clog2(CLKS_PER_BIT), minimum 1.

Ports:
clk  input  1  read-side clock (same clock as the FIFO rclk)
rst  input  1  asynchronous active-high reset
en  input  1  permits starting a new frame; sampled only in IDLE
empty  input  1  FIFO empty flag
rdata  input  WIDTH  FIFO head word; valid whenever empty=0 (first-word fall-through)
re  output  1  FIFO pop strobe; the pop occurs on the clk rising edge where re=1
tx  output  1  serial line; idle high; registered
busy  output  1  high from START to end of STOP; registered
frame_done  output  1  one-cycle pulse during the last clk of the stop bit; registered

Behaviour:
- Reset (asynchronous, immediate) values: state=IDLE, tx=1, busy=0, frame_done=0, re=0, bit counter=0, shift register=0.
- States: IDLE, START, DATA, STOP, plus PARITY when PARITY_EN is defined.
- re = (state==IDLE) & en & ~empty. This is the only combinational output. re is never high outside IDLE.
- IDLE: on an edge with re=1:
  - shift register <= rdata
  - state <= START, tx <= 0, busy <= 1
  - bit counter <= 0
- Bit timing: the counter advances 0..CLKS_PER_BIT-1. When counter==CLKS_PER_BIT-1, the counter wraps to 0 and the FSM moves to the next bit.
- START: after CLKS_PER_BIT cycles, go to DATA and set tx <= shreg[0].
- DATA: at each bit end, shift the register right and set tx to the next LSB. Keep an index 0..WIDTH-1. After bit WIDTH-1, go to STOP (or PARITY) with tx <= 1 (or the parity bit).
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle. Then state <= IDLE and busy <= 0.
- Latency: re is high in cycle N. tx falls at the edge ending cycle N, so tx=0 from cycle N+1.
- Frame length is (WIDTH+2)*CLKS_PER_BIT cycles, with busy=1 for exactly this many cycles.
- Back-to-back frames: at least one IDLE cycle (tx=1, busy=0) separates frames. The next pop can occur in that IDLE cycle.
- en deasserted mid-frame: the current frame completes normally. No further pop occurs while en=0.
- empty rising mid-frame: no effect; the word is already captured.
- Reset mid-frame: the line returns to 1 immediately. The in-flight word is discarded (it has already been popped) and is not retransmitted.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle and the counter is effectively unused. Functional behaviour is otherwise identical.

Optional Feature:
FIFO_UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the WIDTH data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (WIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state or logic exists, and DATA goes directly to STOP.

Test Plan:
- Reset with en=1, empty=1, held for 10 cycles -> tx=1, busy=0, re=0, frame_done=0 throughout.
- WIDTH=3, CLKS_PER_BIT=4, FIFO holds 3'b101, en=1 -> re high for exactly 1 cycle. Then tx is 0,1,0,1,1, each bit held 4 cycles (20 cycles with busy=1). frame_done pulses in cycle 20 and the FIFO becomes empty.
- Same stimulus with FIFO_UART_TX_PARITY_EN defined -> tx is 0,1,0,1,0(parity),1, 24 busy cycles. Word 3'b111 -> parity bit=1.
- FIFO holds 3'b001 then 3'b110 -> two frames separated by exactly one IDLE cycle (tx=1, busy=0). The second re occurs in that IDLE cycle, and the second frame's data bits are 0,1,1.
- en dropped to 0 during DATA of the first of two queued words -> the first frame completes intact, no second re, and the line stays high. Raising en again -> the second frame starts with re in the next cycle.
- rst asserted in the middle of the DATA bit of word 3'b010 -> tx=1, busy=0 asynchronously. After release, a queued word 3'b011 produces a clean full frame. 3'b010 is never retransmitted.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Pops first-word-fall-through FIFO words and sends start / LSB-first data / stop frames on tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int WIDTH        = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             re,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shift;
    logic             r_tx;
    logic             r_busy;
    logic             r_frame_done;
    logic             w_tx_nxt;
    logic             w_busy_nxt;
    logic             w_fd_nxt;
    logic             w_re;
    logic             w_bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             r_par;
`endif

    assign w_re      = (r_state == S_IDLE) & en & ~empty;
    assign w_bit_end = (r_cnt == LAST_CNT);
    assign w_shift   = r_shreg >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_re) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_bit_end && (r_idx == LAST_IDX)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; tx carries the bit that starts on the coming edge.
    always_comb begin
        w_tx_nxt   = r_tx;
        w_busy_nxt = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_re) begin
                    w_tx_nxt   = 1'b0;
                    w_busy_nxt = 1'b1;
                end
            end
            S_START:  if (w_bit_end) w_tx_nxt = r_shreg[0];
            S_DATA: begin
                if (w_bit_end) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_tx_nxt = (r_idx == LAST_IDX) ? r_par : w_shift[0];
`else
                    w_tx_nxt = (r_idx == LAST_IDX) ? 1'b1 : w_shift[0];
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: if (w_bit_end) w_tx_nxt = 1'b1;
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_tx_nxt   = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end
            default: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign w_cnt_nxt = ((r_state == S_IDLE) || w_bit_end) ? '0 : r_cnt + CW'(1);
    assign w_fd_nxt  = (w_state_nxt == S_STOP) && (w_cnt_nxt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shreg      <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_fd_nxt;
            if (w_re)
                r_shreg <= rdata;
            else if ((r_state == S_DATA) && w_bit_end)
                r_shreg <= w_shift;
            if (r_state == S_START)
                r_idx <= '0;
            else if ((r_state == S_DATA) && w_bit_end)
                r_idx <= r_idx + IW'(1);
`ifdef FIFO_UART_TX_PARITY_EN
            if (w_re) r_par <= ^rdata;
`endif
        end
    end

    assign re         = w_re;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
endmodule
